// File: rtl/chk_mon_if.sv
// chk_mon_if: word-qualifier inputs and status outputs of the chk_mon link monitor.
//
//   in_valid, in_sync, correct, clear : driven by the source (master)
//   locked, alarm                     : FSM state and sticky degradation flag
//   word_cnt, err_cnt, lock_loss_cnt  : saturating statistics
//   first_err_vld, first_err_idx      : first-error capture (zero unless
//                                       CHK_MON_FIRST_ERR_EN is defined)
interface chk_mon_if;
  logic        in_valid;
  logic        in_sync;
  logic        correct;
  logic        clear;
  logic        locked;
  logic        alarm;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  lock_loss_cnt;
  logic        first_err_vld;
  logic [31:0] first_err_idx;

  modport master (
    output in_valid, in_sync, correct, clear,
    input  locked, alarm, word_cnt, err_cnt, lock_loss_cnt,
           first_err_vld, first_err_idx
  );

  modport slave (
    input  in_valid, in_sync, correct, clear,
    output locked, alarm, word_cnt, err_cnt, lock_loss_cnt,
           first_err_vld, first_err_idx
  );
endinterface

// File: rtl/chk_mon.sv
// chk_mon: lock/unlock monitor for the decoded-data checker verdict stream.
//
// Runs a HUNT/LOCKED state machine on the per-word `correct` verdict, keeps
// saturating word / error / lock-loss statistics and a sticky alarm that is
// set whenever a locked link falls back to HUNT.
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous active-low reset (same effect as bus.clear)
//   bus      : chk_mon_if.slave - word qualifiers in, status/statistics out
//
// Parameters:
//   LOCK_CNT   : consecutive good data words needed to lock (1..65535)
//   UNLOCK_ERR : errors inside one window that force an unlock (1..WINDOW)
//   WINDOW     : error-rate window length in valid data words (1..65535)
//
// Optional feature macro: CHK_MON_FIRST_ERR_EN - when defined, the index of
// the first bad data word seen while LOCKED is captured; otherwise
// first_err_vld/first_err_idx are tied to zero.
module chk_mon #(
  parameter int LOCK_CNT   = 64,
  parameter int UNLOCK_ERR = 4,
  parameter int WINDOW     = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  chk_mon_if.slave   bus
);

  localparam logic [16:0] LOCK_C   = 17'(LOCK_CNT);
  localparam logic [16:0] UNLOCK_C = 17'(UNLOCK_ERR);
  localparam logic [16:0] WINDOW_C = 17'(WINDOW);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] run_q, run_d;
  logic [15:0] win_q, win_d;
  logic [15:0] werr_q, werr_d;
  logic [15:0] err_q, err_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  loss_q, loss_d;
  logic        alarm_q, alarm_d;

  // Increments are one bit wider so the compare against a 65535 limit
  // cannot alias through a 16-bit wrap.
  logic [16:0] run_inc, win_inc, werr_inc;
  logic        is_data, good_word, bad_word;

  assign run_inc   = {1'b0, run_q}  + 17'd1;
  assign win_inc   = {1'b0, win_q}  + 17'd1;
  assign werr_inc  = {1'b0, werr_q} + 17'd1;
  assign is_data   = bus.in_valid & ~bus.in_sync;
  assign good_word = is_data & bus.correct;
  assign bad_word  = is_data & ~bus.correct;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = err_q;
    word_d  = word_q;
    loss_d  = loss_q;
    alarm_d = alarm_q;

    // Sync words are counted but never reach the FSM.
    if (bus.in_valid) begin
      word_d = sat_inc32(word_q);
    end

    case (state_q)
      HUNT: begin
        if (good_word) begin
          if (run_inc == LOCK_C) begin
            state_d = LOCKED;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            run_d = run_inc[15:0];
          end
        end else if (bad_word) begin
          run_d = '0;
        end
      end
      LOCKED: begin
        if (is_data) begin
          if (bad_word) begin
            err_d = sat_inc16(err_q);
          end
          // Unlock is tested before the window boundary so that an error
          // landing on the closing word still counts against that window.
          if (bad_word && (werr_inc == UNLOCK_C)) begin
            state_d = HUNT;
            alarm_d = 1'b1;
            loss_d  = sat_inc8(loss_q);
            run_d   = '0;
          end else if (win_inc == WINDOW_C) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_inc[15:0];
            if (bad_word) begin
              werr_d = werr_inc[15:0];
            end
          end
        end
      end
    endcase

    // clear discards any word sampled alongside it.
    if (bus.clear) begin
      state_d = HUNT;
      run_d   = '0;
      win_d   = '0;
      werr_d  = '0;
      err_d   = '0;
      word_d  = '0;
      loss_d  = '0;
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
      run_q   <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      word_q  <= '0;
      loss_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      word_q  <= word_d;
      loss_q  <= loss_d;
      alarm_q <= alarm_d;
    end
  end

  assign bus.locked        = (state_q == LOCKED);
  assign bus.alarm         = alarm_q;
  assign bus.word_cnt      = word_q;
  assign bus.err_cnt       = err_q;
  assign bus.lock_loss_cnt = loss_q;

`ifdef CHK_MON_FIRST_ERR_EN
  logic        fev_q, fev_d;
  logic [31:0] fidx_q, fidx_d;

  always_comb begin
    fev_d  = fev_q;
    fidx_d = fidx_q;
    // word_q is the pre-increment count, i.e. the 0-based index of this word.
    if ((state_q == LOCKED) && bad_word && !fev_q) begin
      fev_d  = 1'b1;
      fidx_d = word_q;
    end
    if (bus.clear) begin
      fev_d  = 1'b0;
      fidx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fev_q  <= 1'b0;
      fidx_q <= '0;
    end else begin
      fev_q  <= fev_d;
      fidx_q <= fidx_d;
    end
  end

  assign bus.first_err_vld = fev_q;
  assign bus.first_err_idx = fidx_q;
`else
  assign bus.first_err_vld = 1'b0;
  assign bus.first_err_idx = '0;
`endif

endmodule

// File: tb/tb_chk_mon.sv
// tb_chk_mon: self-checking bench for chk_mon (LOCK_CNT=64, UNLOCK_ERR=4,
// WINDOW=256). A behavioural model of the lock/window rules is stepped on
// every clock and compared against all outputs; directed scenarios add
// constant expectations for the key cases, followed by randomized traffic.
module tb_chk_mon;
  localparam int LOCK_CNT   = 64;
  localparam int UNLOCK_ERR = 4;
  localparam int WINDOW     = 256;

  logic clk;
  logic reset_n;
  chk_mon_if bus();

  chk_mon #(
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_ERR(UNLOCK_ERR),
    .WINDOW    (WINDOW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit          m_locked, m_alarm, m_fv;
  int          m_run, m_win, m_werr, m_err, m_loss;
  int unsigned m_words, m_fidx;

  task automatic model_step(input bit v, input bit s, input bit c, input bit clr, input bit rn);
    if (!rn || clr) begin
      m_locked = 0; m_alarm = 0; m_fv = 0;
      m_run = 0; m_win = 0; m_werr = 0; m_err = 0; m_loss = 0;
      m_words = 0; m_fidx = 0;
    end else if (v) begin
      if (!s) begin
        if (!m_locked) begin
          if (c) begin
            m_run++;
            if (m_run == LOCK_CNT) begin
              m_locked = 1; m_run = 0; m_win = 0; m_werr = 0;
            end
          end else begin
            m_run = 0;
          end
        end else begin
          m_win++;
          if (!c) begin
            if (m_err < 65535) m_err++;
            if (!m_fv) begin
              m_fv = 1;
              m_fidx = m_words;
            end
            m_werr++;
          end
          if (m_werr == UNLOCK_ERR) begin
            m_locked = 0; m_alarm = 1; m_run = 0;
            if (m_loss < 255) m_loss++;
          end else if (m_win == WINDOW) begin
            m_win = 0; m_werr = 0;
          end
        end
      end
      if (m_words != 32'hFFFF_FFFF) m_words++;
    end
  endtask

  task automatic compare_all();
    check_val("locked", 32'(bus.locked), 32'(m_locked));
    check_val("alarm", 32'(bus.alarm), 32'(m_alarm));
    check_val("word_cnt", bus.word_cnt, m_words);
    check_val("err_cnt", 32'(bus.err_cnt), 32'(m_err));
    check_val("lock_loss_cnt", 32'(bus.lock_loss_cnt), 32'(m_loss));
`ifdef CHK_MON_FIRST_ERR_EN
    check_val("first_err_vld", 32'(bus.first_err_vld), 32'(m_fv));
    check_val("first_err_idx", bus.first_err_idx, m_fidx);
`else
    check_val("first_err_vld", 32'(bus.first_err_vld), 32'd0);
    check_val("first_err_idx", bus.first_err_idx, 32'd0);
`endif
  endtask

  // One clock: drive, let the edge sample, step the model, compare at edge+1.
  task automatic cyc(input bit v, input bit s, input bit c, input bit clr, input bit rn);
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.correct  = c;
    bus.clear    = clr;
    reset_n      = rn;
    @(posedge clk);
    model_step(v, s, c, clr, rn);
    #1;
    compare_all();
  endtask

  task automatic good(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 1);
  endtask

  task automatic bad();
    cyc(1, 0, 0, 0, 1);
  endtask

  task automatic do_clear();
    cyc(0, 0, 0, 1, 1);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_sync  = 0;
    bus.correct  = 0;
    bus.clear    = 0;
    reset_n      = 0;

    // Reset
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_val("rst_locked", 32'(bus.locked), 32'd0);
    check_val("rst_word_cnt", bus.word_cnt, 32'd0);
    check_val("rst_first_idx", bus.first_err_idx, 32'd0);

    // Lock: a bad word restarts the run
    good(63);
    bad();
    good(63);
    check_val("lock_pre_locked", 32'(bus.locked), 32'd0);
    good(1);
    check_val("lock_locked", 32'(bus.locked), 32'd1);
    check_val("lock_word_cnt", bus.word_cnt, 32'd128);
    check_val("lock_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Unlock: four errors spaced 10 good words apart
    bad(); good(10); bad(); good(10); bad();
    check_val("unlock_3err_locked", 32'(bus.locked), 32'd1);
    good(10); bad();
    check_val("unlock_locked", 32'(bus.locked), 32'd0);
    check_val("unlock_alarm", 32'(bus.alarm), 32'd1);
    check_val("unlock_loss", 32'(bus.lock_loss_cnt), 32'd1);
    check_val("unlock_err_cnt", 32'(bus.err_cnt), 32'd4);
`ifdef CHK_MON_FIRST_ERR_EN
    check_val("unlock_first_idx", bus.first_err_idx, 32'd128);
`endif

    // Clear resets everything
    do_clear();
    check_val("clr_alarm", 32'(bus.alarm), 32'd0);
    check_val("clr_loss", 32'(bus.lock_loss_cnt), 32'd0);

    // Window reset: 3 errors in each of two windows keeps lock
    good(64);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < WINDOW; i++)
        cyc(1, 0, !(i == 10 || i == 20 || i == 30), 0, 1);
    check_val("win_locked", 32'(bus.locked), 32'd1);
    check_val("win_err_cnt", 32'(bus.err_cnt), 32'd6);
    check_val("win_alarm", 32'(bus.alarm), 32'd0);

    // Final error on the window-closing word: unlock wins
    do_clear();
    good(64);
    for (int i = 0; i < WINDOW; i++)
      cyc(1, 0, !(i <= 2 || i == WINDOW - 1), 0, 1);
    check_val("bnd_same_locked", 32'(bus.locked), 32'd0);
    check_val("bnd_same_alarm", 32'(bus.alarm), 32'd1);

    // Fourth error one word after the boundary starts a fresh window
    do_clear();
    good(64);
    for (int i = 0; i < WINDOW; i++)
      cyc(1, 0, !(i <= 2), 0, 1);
    bad();
    check_val("bnd_next_locked", 32'(bus.locked), 32'd1);
    check_val("bnd_next_err_cnt", 32'(bus.err_cnt), 32'd4);

    // Sync words (correct=0) and gaps are transparent in HUNT
    do_clear();
    for (int i = 0; i < 64; i++) begin
      cyc(1, 1, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      if (i == 63) check_val("sync_pre_locked", 32'(bus.locked), 32'd0);
      good(1);
    end
    check_val("sync_locked", 32'(bus.locked), 32'd1);
    check_val("sync_word_cnt", bus.word_cnt, 32'd128);

    // First-error capture: lock at index 63, first error at index 100
    do_clear();
    good(64);
    good(36);
    bad(); bad(); bad();
    check_val("ferr_locked", 32'(bus.locked), 32'd1);
`ifdef CHK_MON_FIRST_ERR_EN
    check_val("ferr_vld", 32'(bus.first_err_vld), 32'd1);
    check_val("ferr_idx", bus.first_err_idx, 32'd100);
`else
    check_val("ferr_vld_off", 32'(bus.first_err_vld), 32'd0);
    check_val("ferr_idx_off", bus.first_err_idx, 32'd0);
`endif

    // Clear colliding with a bad word while locked
    cyc(1, 0, 0, 1, 1);
    check_val("coll_locked", 32'(bus.locked), 32'd0);
    check_val("coll_err_cnt", 32'(bus.err_cnt), 32'd0);
    check_val("coll_word_cnt", bus.word_cnt, 32'd0);

    // Reset mid-window leaves no residual window errors
    good(64);
    bad(); bad();
    cyc(1, 0, 0, 0, 0);
    good(64);
    bad(); bad(); bad();
    check_val("rstmid_locked", 32'(bus.locked), 32'd1);
    check_val("rstmid_err_cnt", 32'(bus.err_cnt), 32'd3);

    // lock_loss_cnt saturation
    do_clear();
    for (int k = 0; k < 260; k++) begin
      good(64);
      bad(); bad(); bad(); bad();
    end
    check_val("sat_loss", 32'(bus.lock_loss_cnt), 32'd255);
    check_val("sat_err_cnt", 32'(bus.err_cnt), 32'd1040);

    // Randomized traffic at several error rates
    for (int p = 0; p < 4; p++) begin
      int unsigned bad_div;
      case (p)
        0: bad_div = 400;
        1: bad_div = 60;
        2: bad_div = 20;
        default: bad_div = 8;
      endcase
      for (int i = 0; i < 2500; i++) begin
        bit v, s, c, clr, rn;
        v   = ($urandom_range(0, 9) < 8);
        s   = ($urandom_range(0, 9) == 0);
        c   = ($urandom_range(0, bad_div - 1) != 0);
        clr = ($urandom_range(0, 1499) == 0);
        rn  = ($urandom_range(0, 2499) != 0);
        cyc(v, s, c, clr, rn);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
